// File: rtl/trig_capture.sv
// rtl/trig_capture.sv - triggered frame capture into a DEPTH-entry sample buffer
// Arm, wait for a level crossing (or a timeout in auto mode), capture DEPTH samples, then freeze.
module trig_capture #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 400,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_fall,
  input  logic              auto_en,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              auto_trig
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic               auto_trig_q, auto_trig_d;
  logic [DATA_W-1:0]  rd_data_q;

  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic               cross_hit;
  logic               timeout_hit;
  logic               rd_in_range;

  logic [DATA_W-1:0]  mem [0:DEPTH-1];

  always_comb begin
    if (trig_fall)
      cross_hit = (prev_q >= trig_level) && (sample_in < trig_level);
    else
      cross_hit = (prev_q < trig_level) && (sample_in >= trig_level);
  end

  assign timeout_hit = auto_en && (tcnt_q == CNT_W'(TIMEOUT - 1));
  assign rd_in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    tcnt_d      = tcnt_q;
    wr_ptr_d    = wr_ptr_q;
    auto_trig_d = auto_trig_q;
    we          = 1'b0;
    waddr       = wr_ptr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d     = S_ARMED;
          auto_trig_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (sample_valid) begin
          prev_d  = sample_in;
          tcnt_d  = '0;
          state_d = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
        if (sample_valid) begin
          // A genuine crossing wins over a coincident timeout, so auto_trig stays clear.
          if (cross_hit || timeout_hit) begin
            we          = 1'b1;
            waddr       = '0;
            wr_ptr_d    = ADDR_W'(1);
            auto_trig_d = !cross_hit;
            state_d     = S_CAPTURE;
          end else begin
            prev_d = sample_in;
            if (tcnt_q != CNT_W'(TIMEOUT - 1))
              tcnt_d = tcnt_q + CNT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        if (sample_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == ADDR_W'(DEPTH - 1))
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      tcnt_q      <= '0;
      wr_ptr_q    <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tcnt_q      <= tcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  // Write and read ports kept in separate processes so the buffer maps to simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data_q <= '0;
    else if (rd_in_range)
      rd_data_q <= mem[rd_addr];
    else
      rd_data_q <= '0;
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q == S_ARMED) || (state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign auto_trig = auto_trig_q;

endmodule

// File: tb/tb_trig_capture.sv
// tb/tb_trig_capture.sv - self-checking bench for trig_capture
// Scenario tasks run in sequence; read results are queued as expectations and popped on output.
module tb_trig_capture;
  localparam int DW      = 12;
  localparam int DEPTH   = 400;
  localparam int AW      = 9;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [DW-1:0] trig_level;
  logic          trig_fall;
  logic          auto_en;
  logic          arm;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          auto_trig;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_buf [DEPTH];
  logic [DW-1:0] sb_q [$];

  trig_capture #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_fall(trig_fall), .auto_en(auto_en), .arm(arm),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .auto_trig(auto_trig)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit v, input int x, input bit a);
    sample_valid = v;
    sample_in    = DW'(x);
    arm          = a;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic read_frame(input string name);
    logic [DW-1:0] exp;
    sample_valid = 1'b1;
    for (int a = 0; a <= DEPTH; a++) begin
      rd_addr   = AW'(a);
      sample_in = DW'($urandom_range(0, 4095));
      sb_q.push_back(a < DEPTH ? exp_buf[a] : '0);
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL %s addr %0d: got %0d expected %0d", name, a, rd_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 123, 1);
    drive(1, 456, 0);
    checks++;
    if ({busy, done, auto_trig} !== 3'b000 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b auto=%b rd=%0d expected 0 0 0 0", busy, done, auto_trig, rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_rising();
    trig_level = DW'(1000);
    trig_fall  = 1'b0;
    auto_en    = 1'b0;
    drive(1, 998, 1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rising_busy: got %b expected 1", busy); end
    drive(1, 999, 0);
    for (int k = 1; k <= 400; k++) begin
      drive(1, 999 + k, 0);
      if (k == 399) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rising_done_early: got %b expected 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || auto_trig !== 1'b0) begin
      errors++;
      $display("FAIL rising_done: got done=%b busy=%b auto=%b expected 1 0 0", done, busy, auto_trig);
    end
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = DW'(1000 + i);
    read_frame("rising_frame");
  endtask

  task automatic test_read_b2b();
    int addrs [4] = '{0, 1, 399, 400};
    int exps  [4] = '{1000, 1001, 1399, 0};
    logic [DW-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(addrs[i]);
      sb_q.push_back(DW'(exps[i]));
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL read_b2b addr %0d: got %0d expected %0d", addrs[i], rd_data, exp);
      end
    end
  endtask

  task automatic test_falling();
    trig_level = DW'(2048);
    trig_fall  = 1'b1;
    drive(1, 2050, 1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL falling_arm: got done=%b busy=%b expected 0 1", done, busy);
    end
    drive(1, 2049, 0);
    for (int k = 1; k <= 401; k++) begin
      drive(1, 2049 - k, 0);
      if (k == 400) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL falling_done_early: got %b expected 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL falling_done: got %b expected 1", done); end
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = DW'(2047 - i);
    read_frame("falling_frame");
  endtask

  task automatic test_auto();
    trig_level = DW'(1000);
    trig_fall  = 1'b0;
    auto_en    = 1'b1;
    drive(1, 500, 1);
    drive(1, 500, 0);
    for (int n = 1; n <= TIMEOUT + DEPTH - 1; n++) begin
      drive(1, 500, 0);
      if (n == TIMEOUT - 1 || n == TIMEOUT + DEPTH - 2) begin
        checks++;
        if (done !== 1'b0 || auto_trig !== 1'b0 && n == TIMEOUT - 1) begin
          errors++;
          $display("FAIL auto_early n=%0d: got done=%b auto=%b expected 0 0", n, done, auto_trig);
        end
      end
      if (n == TIMEOUT) begin
        checks++;
        if (auto_trig !== 1'b1) begin errors++; $display("FAIL auto_trig_set: got %b expected 1", auto_trig); end
      end
    end
    checks++;
    if (done !== 1'b1 || auto_trig !== 1'b1) begin
      errors++;
      $display("FAIL auto_done: got done=%b auto=%b expected 1 1", done, auto_trig);
    end
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = DW'(500);
    read_frame("auto_frame");

    auto_en = 1'b0;
    drive(1, 500, 1);
    checks++;
    if (auto_trig !== 1'b0) begin errors++; $display("FAIL auto_clear: got %b expected 0", auto_trig); end
    for (int n = 0; n < 1500; n++) drive(1, 500, 0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL noauto_wait: got busy=%b done=%b expected 1 0", busy, done);
    end
    rst = 1'b1;
    drive(0, 0, 0);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL noauto_rst: got busy=%b expected 0", busy); end
  endtask

  task automatic test_gaps();
    auto_en = 1'b0;
    drive(1, 998, 1);
    drive(1, 999, 0);
    for (int e = 1; e <= 800; e++) begin
      if (e % 2 == 1) drive(0, 3000, 0);
      else            drive(1, 999 + e / 2, 0);
      if (e == 799) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL gaps_done_early: got %b expected 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b expected 1", done); end
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = DW'(1000 + i);
    read_frame("gaps_frame");
  endtask

  task automatic test_arm_ignore();
    drive(1, 998, 1);
    drive(1, 999, 0);
    for (int k = 1; k <= 400; k++) begin
      drive(1, 999 + k, (k == 1) || (k == 100));
      if (k == 399) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL arm_ign_done_early: got %b expected 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL arm_ign_done: got %b expected 1", done); end
    read_frame("arm_ign_frame");
  endtask

  task automatic test_collision_rst();
    logic [DW-1:0] exp;
    drive(1, 998, 1);
    drive(1, 999, 0);
    drive(1, 1000, 0);
    for (int k = 1; k <= 200; k++) begin
      if (k == 10) begin
        rd_addr = AW'(10);
        sb_q.push_back(DW'(1010));
      end
      if (k == 11) sb_q.push_back(DW'(3010));
      drive(1, 3000 + k, 0);
      if (k == 10 || k == 11) begin
        exp = sb_q.pop_front();
        checks++;
        if (rd_data !== exp) begin
          errors++;
          $display("FAIL collision k=%0d: got %0d expected %0d", k, rd_data, exp);
        end
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    drive(1, 3201, 0);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b expected 0 0", busy, done);
    end
    for (int k = 0; k < 20; k++) drive(1, 3300 + k, 0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    trig_level   = '0;
    trig_fall    = 1'b0;
    auto_en      = 1'b0;
    arm          = 1'b0;
    rd_addr      = '0;
    test_reset();
    test_rising();
    test_read_b2b();
    test_falling();
    test_auto();
    test_gaps();
    test_arm_ignore();
    test_collision_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
